// File: rtl/tube_frame_reader.sv
// rtl/tube_frame_reader.sv - tube-event FIFO consumer: frame parser, ID checker, hit emitter
//
// Purpose: pops words from the tube-event FIFO, walks each 32-word event frame
// plus its terminator, checks every tube-ID byte against the fixed readout
// order, and emits one hit record per fired tube over a valid/ready handshake.
// It also keeps good-frame and framing-error counters.
//
// Ports:
//   clk100       in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   fifo_dout    in   FIFO read data, [15:8] cycle count, [7:0] tube ID
//   fifo_valid   in   fifo_dout holds a popped word this cycle
//   fifo_empty   in   FIFO has no words
//   fifo_rd_en   out  single-cycle pop request
//   hit_valid    out  hit record valid
//   hit_ready    in   downstream accepts the hit record
//   hit_tube     out  tube index 0..31
//   hit_time     out  cycle count from the data word
//   hit_event    out  event_count at frame start
//   event_done   out  one-cycle pulse on a valid terminator
//   event_hits   out  hits in the completed frame, valid with event_done
//   frame_err    out  one-cycle pulse on any framing error
//   event_count  out  completed good frames, wrapping
//   err_count    out  framing errors, saturating
module tube_frame_reader #(
    parameter int unsigned FRAME_WORDS = 32,
    parameter logic [15:0] TERM_WORD   = 16'hFFFF
) (
    input  logic        clk100,
    input  logic        rst_n,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_valid,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        hit_valid,
    input  logic        hit_ready,
    output logic [4:0]  hit_tube,
    output logic [7:0]  hit_time,
    output logic [15:0] hit_event,
    output logic        event_done,
    output logic [5:0]  event_hits,
    output logic        frame_err,
    output logic [15:0] event_count,
    output logic [15:0] err_count
);

    localparam logic [4:0] LAST_IDX = 5'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BODY   = 2'd1,
        S_TERM   = 2'd2,
        S_RESYNC = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_rd_pending;
    logic [4:0]  r_idx;
    logic        r_hit_valid;
    logic [4:0]  r_hit_tube;
    logic [7:0]  r_hit_time;
    logic [15:0] r_hit_event;
    logic        r_event_done;
    logic [5:0]  r_event_hits;
    logic        r_frame_err;
    logic [15:0] r_event_count;
    logic [15:0] r_err_count;

    logic        w_rd_en;
    logic        w_take;
    logic        w_is_term;
    logic [7:0]  w_word_id;
    logic [7:0]  w_word_data;
    logic [4:0]  w_chk_idx;
    logic [7:0]  w_exp_id;
    logic        w_id_ok;

    logic        w_frame_start;
    logic        w_frame_word;
    logic        w_word_ok;
    logic        w_hit_load;
    logic        w_done;
    logic        w_err;

    // Only one read in flight, and only when the hit slot is free or drains
    // this cycle, so a captured word can never overwrite a held hit.
    // rst_n gating keeps the pop request low while reset is asserted.
    assign w_rd_en = rst_n && !fifo_empty && !r_rd_pending &&
                     (!r_hit_valid || hit_ready);

    assign w_take      = r_rd_pending && fifo_valid;
    assign w_is_term   = (fifo_dout == TERM_WORD);
    assign w_word_id   = fifo_dout[7:0];
    assign w_word_data = fifo_dout[15:8];
    // A frame-starting word arrives in IDLE and is always index 0.
    assign w_chk_idx   = (r_state == S_IDLE) ? 5'd0 : r_idx;
    assign w_exp_id    = {w_chk_idx[4] ? 4'b0010 : 4'b1100,
                          w_chk_idx[3], w_chk_idx[0], w_chk_idx[1], w_chk_idx[2]};
    assign w_id_ok     = (w_word_id == w_exp_id);

    // State register
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (w_take) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_is_term) begin
                        if (!w_id_ok)                    w_state_next = S_RESYNC;
                        else if (w_chk_idx == LAST_IDX)  w_state_next = S_TERM;
                        else                             w_state_next = S_BODY;
                    end
                end
                S_BODY: begin
                    if (w_is_term)                       w_state_next = S_IDLE;
                    else if (!w_id_ok)                   w_state_next = S_RESYNC;
                    else if (r_idx == LAST_IDX)          w_state_next = S_TERM;
                end
                S_TERM: begin
                    w_state_next = w_is_term ? S_IDLE : S_RESYNC;
                end
                default: begin
                    if (w_is_term)                       w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Output decode: per-word strobes driving the datapath registers
    always_comb begin
        w_frame_start = 1'b0;
        w_frame_word  = 1'b0;
        w_word_ok     = 1'b0;
        w_hit_load    = 1'b0;
        w_done        = 1'b0;
        w_err         = 1'b0;
        if (w_take) begin
            w_frame_start = (r_state == S_IDLE) && !w_is_term;
            w_frame_word  = !w_is_term && ((r_state == S_IDLE) || (r_state == S_BODY));
            w_word_ok     = w_frame_word && w_id_ok;
            w_hit_load    = w_word_ok && (w_word_data != 8'd0);
            w_done        = (r_state == S_TERM) && w_is_term;
            w_err         = (w_frame_word && !w_id_ok) ||
                            ((r_state == S_BODY) && w_is_term) ||
                            ((r_state == S_TERM) && !w_is_term);
        end
    end

    // Datapath
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pending  <= 1'b0;
            r_idx         <= 5'd0;
            r_hit_valid   <= 1'b0;
            r_hit_tube    <= 5'd0;
            r_hit_time    <= 8'd0;
            r_hit_event   <= 16'd0;
            r_event_done  <= 1'b0;
            r_event_hits  <= 6'd0;
            r_frame_err   <= 1'b0;
            r_event_count <= 16'd0;
            r_err_count   <= 16'd0;
        end else begin
            if (w_rd_en) begin
                r_rd_pending <= 1'b1;
            end else if (fifo_valid) begin
                r_rd_pending <= 1'b0;
            end

            if (w_word_ok) begin
                r_idx <= w_chk_idx + 5'd1;
            end

            if (w_hit_load) begin
                r_hit_valid <= 1'b1;
                r_hit_tube  <= w_chk_idx;
                r_hit_time  <= w_word_data;
                r_hit_event <= r_event_count;
            end else if (r_hit_valid && hit_ready) begin
                r_hit_valid <= 1'b0;
            end

            if (w_frame_start) begin
                r_event_hits <= w_hit_load ? 6'd1 : 6'd0;
            end else if (w_hit_load) begin
                r_event_hits <= r_event_hits + 6'd1;
            end

            r_event_done <= w_done;
            r_frame_err  <= w_err;

            if (w_done) begin
                r_event_count <= r_event_count + 16'd1;
            end
            if (w_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign fifo_rd_en  = w_rd_en;
    assign hit_valid   = r_hit_valid;
    assign hit_tube    = r_hit_tube;
    assign hit_time    = r_hit_time;
    assign hit_event   = r_hit_event;
    assign event_done  = r_event_done;
    assign event_hits  = r_event_hits;
    assign frame_err   = r_frame_err;
    assign event_count = r_event_count;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_tube_frame_reader.sv
// tb/tb_tube_frame_reader.sv - scoreboard bench for tube_frame_reader
module tb_tube_frame_reader;

    logic        clk100 = 1'b0;
    logic        rst_n;
    logic [15:0] fifo_dout;
    logic        fifo_valid;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        hit_valid;
    logic        hit_ready;
    logic [4:0]  hit_tube;
    logic [7:0]  hit_time;
    logic [15:0] hit_event;
    logic        event_done;
    logic [5:0]  event_hits;
    logic        frame_err;
    logic [15:0] event_count;
    logic [15:0] err_count;

    always #5 clk100 = ~clk100;

    tube_frame_reader dut (
        .clk100      (clk100),
        .rst_n       (rst_n),
        .fifo_dout   (fifo_dout),
        .fifo_valid  (fifo_valid),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_tube    (hit_tube),
        .hit_time    (hit_time),
        .hit_event   (hit_event),
        .event_done  (event_done),
        .event_hits  (event_hits),
        .frame_err   (frame_err),
        .event_count (event_count),
        .err_count   (err_count)
    );

    typedef struct {
        bit is_err;
        int hits;
        int cnt;
    } ev_t;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] inflight_word = 16'h0;
    int          lat_cnt = 0;
    int          lat = 1;
    bit          spurious_req = 0;
    bit          ready_rand = 0;
    bit          stall_arm = 0;
    int          stall_cnt = 0;
    logic [28:0] stall_fields = '0;

    logic [28:0] hit_q[$];
    ev_t         ev_q[$];
    int          model_ev = 0;
    int          model_err = 0;
    logic [7:0]  fr_data [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_id(input int i);
        logic [4:0] b;
        b = 5'(i);
        return {b[4] ? 4'b0010 : 4'b1100, b[3], b[0], b[1], b[2]};
    endfunction

    task automatic push_err();
        ev_t e;
        if (model_err < 65535) model_err++;
        e.is_err = 1'b1;
        e.hits   = 0;
        e.cnt    = model_err;
        ev_q.push_back(e);
    endtask

    // Queues one frame into the FIFO model and its expected outcome into the
    // scoreboard. bad_idx / early_idx < 0 disable those faults.
    task automatic send_frame(input int bad_idx, input int early_idx, input bit no_term);
        int  hits;
        ev_t e;
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] id;
            if (i == early_idx) begin
                fifo_q.push_back(16'hFFFF);
                push_err();
                return;
            end
            id = (i == bad_idx) ? 8'hC0 : exp_id(i);
            fifo_q.push_back({fr_data[i], id});
            if (i == bad_idx) begin
                for (int j = i + 1; j < 32; j++) fifo_q.push_back({fr_data[j], exp_id(j)});
                fifo_q.push_back(16'hFFFF);
                push_err();
                return;
            end
            if (fr_data[i] != 8'd0) begin
                hit_q.push_back({5'(i), fr_data[i], 16'(model_ev)});
                hits++;
            end
        end
        if (no_term) begin
            fifo_q.push_back(16'h05C0);
            fifo_q.push_back(16'hFFFF);
            push_err();
        end else begin
            fifo_q.push_back(16'hFFFF);
            model_ev = (model_ev + 1) & 32'hFFFF;
            e.is_err = 1'b0;
            e.hits   = hits;
            e.cnt    = model_ev;
            ev_q.push_back(e);
        end
    endtask

    task automatic clear_data();
        for (int i = 0; i < 32; i++) fr_data[i] = 8'd0;
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((fifo_q.size() != 0 || lat_cnt != 0 || hit_q.size() != 0 ||
                ev_q.size() != 0 || stall_cnt != 0) && cyc < 4000) begin
            @(negedge clk100);
            cyc++;
        end
        repeat (4) @(negedge clk100);
        check_eq({tag, "_pending"}, 32'(hit_q.size() + ev_q.size() + fifo_q.size()), 32'd0);
        check_eq({tag, "_event_count"}, 32'(event_count), 32'(model_ev));
        check_eq({tag, "_err_count"}, 32'(err_count), 32'(model_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_en"},       32'(fifo_rd_en),  32'd0);
        check_eq({tag, "_hit_valid"},   32'(hit_valid),   32'd0);
        check_eq({tag, "_hit_fields"},  32'({hit_tube, hit_time, hit_event}), 32'd0);
        check_eq({tag, "_event_done"},  32'(event_done),  32'd0);
        check_eq({tag, "_event_hits"},  32'(event_hits),  32'd0);
        check_eq({tag, "_frame_err"},   32'(frame_err),   32'd0);
        check_eq({tag, "_event_count"}, 32'(event_count), 32'd0);
        check_eq({tag, "_err_count"},   32'(err_count),   32'd0);
    endtask

    // FIFO read side and downstream ready, driven just after each rising edge
    initial begin
        fifo_valid = 1'b0;
        fifo_dout  = 16'hFFFF;
        fifo_empty = 1'b1;
        hit_ready  = 1'b1;
        forever begin
            @(posedge clk100);
            #1;
            fifo_valid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    fifo_valid = 1'b1;
                    fifo_dout  = inflight_word;
                end
            end else if (spurious_req) begin
                spurious_req = 0;
                fifo_valid   = 1'b1;
                fifo_dout    = 16'h12C0;
            end
            fifo_empty = (fifo_q.size() == 0);
            if (stall_arm && hit_valid) begin
                stall_arm    = 0;
                stall_cnt    = 20;
                stall_fields = {hit_tube, hit_time, hit_event};
            end
            if (stall_cnt > 0) hit_ready = 1'b0;
            else hit_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the FIFO model on rd_en and scores hits and events
    initial begin
        forever begin
            @(negedge clk100);
            if (rst_n) begin
                if (fifo_rd_en) begin
                    if (fifo_q.size() == 0 || lat_cnt != 0) begin
                        check_eq("rd_en_illegal", 32'(fifo_rd_en), 32'd0);
                    end else begin
                        inflight_word = fifo_q.pop_front();
                        lat_cnt = lat;
                    end
                end
                if (stall_cnt > 0) begin
                    check_eq("stall_rd_en", 32'(fifo_rd_en), 32'd0);
                    check_eq("stall_hit_valid", 32'(hit_valid), 32'd1);
                    check_eq("stall_fields", 32'({hit_tube, hit_time, hit_event}), 32'(stall_fields));
                    stall_cnt--;
                end
                if (hit_valid && hit_ready) begin
                    logic [31:0] exp_hit;
                    exp_hit = (hit_q.size() > 0) ? {3'b0, hit_q.pop_front()} : 32'hFFFF_FFFF;
                    check_eq("hit", {3'b0, hit_tube, hit_time, hit_event}, exp_hit);
                end
                if (event_done || frame_err) begin
                    if (ev_q.size() == 0) begin
                        check_eq("ev_unexpected", 32'({event_done, frame_err}), 32'd0);
                    end else begin
                        ev_t e;
                        e = ev_q.pop_front();
                        check_eq("ev_kind", 32'({event_done, frame_err}), e.is_err ? 32'd1 : 32'd2);
                        if (!e.is_err) begin
                            check_eq("ev_hits", 32'(event_hits), 32'(e.hits));
                            check_eq("ev_count", 32'(event_count), 32'(e.cnt));
                        end else begin
                            check_eq("ev_err_count", 32'(err_count), 32'(e.cnt));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clear_data();
        repeat (3) @(negedge clk100);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Good frame with leading fillers: hits at tubes 5 and 20
        lat = 1;
        for (int i = 0; i < 3; i++) fifo_q.push_back(16'hFFFF);
        fr_data[5]  = 8'h12;
        fr_data[20] = 8'h80;
        send_frame(-1, -1, 1'b0);
        drain("good");

        // Backpressure: every tube fires, first hit stalled for 20 cycles
        lat = 2;
        for (int i = 0; i < 32; i++) fr_data[i] = 8'(8'h40 + i);
        stall_arm = 1;
        send_frame(-1, -1, 1'b0);
        drain("backpressure");

        // ID mismatch at index 7, then a good frame
        lat = 3;
        ready_rand = 1;
        clear_data();
        fr_data[2]  = 8'h21;
        fr_data[9]  = 8'h99;
        fr_data[31] = 8'h3C;
        send_frame(7, -1, 1'b0);
        send_frame(-1, -1, 1'b0);
        drain("mismatch");

        // Early terminator at index 10, immediately followed by a good frame
        lat = 1;
        clear_data();
        fr_data[3]  = 8'h31;
        fr_data[16] = 8'h5A;
        send_frame(-1, 10, 1'b0);
        send_frame(-1, -1, 1'b0);
        drain("early_term");

        // Missing terminator, then resync and a good frame
        ready_rand = 0;
        clear_data();
        fr_data[0]  = 8'h01;
        fr_data[31] = 8'hFE;
        send_frame(-1, -1, 1'b1);
        fr_data[0] = 8'h00;
        send_frame(-1, -1, 1'b0);
        drain("missing_term");

        // fifo_valid with no read outstanding must be ignored
        spurious_req = 1;
        repeat (5) @(negedge clk100);
        drain("spurious");

        // Counter wrap: preload event_count near the top, run two frames
        force dut.r_event_count = 16'hFFFE;
        @(negedge clk100);
        release dut.r_event_count;
        model_ev = 16'hFFFE;
        clear_data();
        fr_data[12] = 8'h77;
        send_frame(-1, -1, 1'b0);
        send_frame(-1, -1, 1'b0);
        drain("wrap");

        // Reset mid-frame, then a clean frame
        clear_data();
        for (int i = 0; i < 12; i++) fifo_q.push_back({8'h00, exp_id(i)});
        begin
            int cyc;
            cyc = 0;
            while (fifo_q.size() > 6 && cyc < 500) begin
                @(negedge clk100);
                cyc++;
            end
            check_eq("midframe_progress", 32'(fifo_q.size() <= 6), 32'd1);
        end
        @(negedge clk100);
        rst_n = 1'b0;
        fifo_q.delete();
        lat_cnt = 0;
        repeat (2) @(negedge clk100);
        check_reset_outputs("midreset");
        model_ev  = 0;
        model_err = 0;
        rst_n = 1'b1;
        fr_data[0]  = 8'h33;
        fr_data[31] = 8'h44;
        send_frame(-1, -1, 1'b0);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tube_frame_reader.md
# tube_frame_reader

Drains the tube-event FIFO from its read port, on the same 100 MHz clock as the writer. It parses each 32-word event frame plus its 0xFFFF terminator and checks every word's tube-ID byte against the fixed readout order. Each fired tube is emitted as a hit record over a valid/ready handshake. This is the FPGA-side consumer that replaces raw Raspberry Pi word polling with validated, per-hit output and event/error bookkeeping.

## Interface
Parameters:
- FRAME_WORDS, 32: data words per event frame.
- TERM_WORD, 16'hFFFF: terminator and idle-filler word.

Ports:
- clk100  in  1  system clock, 100 MHz; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- fifo_dout  in  16  FIFO read data; [15:8] = clock-cycle count, [7:0] = tube ID.
- fifo_valid  in  1  fifo_dout holds a popped word this cycle.
- fifo_empty  in  1  FIFO has no words.
- fifo_rd_en  out  1  single-cycle pop request.
- hit_valid  out  1  hit record valid.
- hit_ready  in  1  downstream accepts the hit record.
- hit_tube  out  5  tube index 0..31 (0-7 = 3A, 8-15 = 3B, 16-23 = 4A, 24-31 = 4B).
- hit_time  out  8  clock-cycle count from the data word.
- hit_event  out  16  event_count value when the frame started.
- event_done  out  1  one-cycle pulse on a valid terminator.
- event_hits  out  6  number of hits in the completed frame; valid with event_done.
- frame_err  out  1  one-cycle pulse on any framing error.
- event_count  out  16  completed good frames; wraps 0xFFFF -> 0.
- err_count  out  16  framing errors; saturates at 0xFFFF.

## Operation
- Expected ID for word index i (0..31) is {i[4] ? 4'b0010 : 4'b1100, i[3], i[0], i[1], i[2]}.
  - i=0 gives 8'hC0; i=1 gives 8'hC4; i=16 gives 8'h20; i=31 gives 8'h2F.
- A data byte of 0 means the tube did not fire, and no hit is emitted. Any nonzero data byte emits hit {tube=i, time=data, event}.
- States:
  - IDLE: a TERM_WORD is discarded as filler. Any other word starts a frame and is checked as index 0 -> BODY.
  - BODY: the word at index i is checked against the expected ID.
    - Match with i=31 -> TERM.
    - ID mismatch -> error, go to RESYNC.
    - TERM_WORD received early -> error, go to IDLE.
  - TERM: TERM_WORD -> event_done, event_count+1, go to IDLE. Any other word -> error, go to RESYNC.
  - RESYNC: discard words until a TERM_WORD arrives, then go to IDLE.
- On an error:
  - frame_err pulses and err_count increments, saturating.
  - Hits already emitted for the frame are not retracted.
  - event_done does not pulse, and event_count is unchanged.
- event_hits counts hits emitted in the current frame and clears at frame start.

## Timing
- Reset values: fifo_rd_en=0, hit_valid=0, hit_tube=0, hit_time=0, hit_event=0, event_done=0, event_hits=0, frame_err=0, event_count=0, err_count=0; state = IDLE.
- fifo_rd_en is asserted for one cycle only when fifo_empty=0, no read is outstanding, and hit_valid=0 (or hit_valid&&hit_ready this cycle).
- A read stays outstanding until fifo_valid. Latency of 1 or more cycles is accepted, and fifo_valid without an outstanding read is ignored.
- Word captured at edge N (fifo_valid=1): hit_valid, event_done and frame_err are registered at N+1.
- hit_valid holds with stable fields until hit_ready; a transfer occurs on the cycle where both are high.
- Steady throughput is one word per 2 cycles with hit_ready tied high.
- Simultaneous hit transfer and fifo_valid in the same cycle: the new hit loads on the following edge with no bubble or loss.
- A rst_n assertion mid-frame returns immediately to reset values and discards any outstanding read. The next non-TERM word after reset is treated as a frame start.

## Test plan
- Good frame: 3 filler 0xFFFF words, then 32 words with correct IDs and data 0 except i=5 data=8'h12 and i=20 data=8'h80, then 0xFFFF -> exactly 2 hits: {5,0x12,0} and {20,0x80,0}. Then event_done with event_hits=2, event_count=1, err_count=0.
- Backpressure: hold hit_ready=0 for 20 cycles on the first hit of a frame with all 32 tubes fired -> no fifo_rd_en while stalled, hit fields stable. Then all 32 hits arrive in order with tube 0..31.
- ID mismatch: word index 7 carries ID 8'hC0 -> frame_err once, err_count=1. Remaining words are discarded until 0xFFFF, then the next good frame completes with event_count=1.
- Early terminator: 0xFFFF arrives at index 10 -> frame_err, state IDLE. An immediately following good frame completes normally.
- Missing terminator: 33rd word is 16'h05C0 -> frame_err, no event_done, RESYNC until 0xFFFF.
- Counters and reset: preload via 65536 good frames -> event_count wraps to 0. Pulse rst_n low mid-frame -> all outputs return to 0 and the next frame parses cleanly.
